// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, arbiter FSM states, op legality helper.
package alu_pkg;

    localparam int ALU_WIDTH  = 32;
    localparam int ALU_CTRL_W = 4;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLT    = 4'd5;
    localparam logic [3:0] ALU_SLTU   = 4'd6;
    localparam logic [3:0] ALU_LUIA   = 4'd7;
    localparam logic [3:0] ALU_AUIPC  = 4'd8;
    localparam logic [3:0] ALU_LUI    = 4'd9;
    localparam logic [3:0] ALU_SLL    = 4'd10;
    localparam logic [3:0] ALU_SRA    = 4'd11;
    localparam logic [3:0] ALU_SRL    = 4'd12;
    localparam logic [3:0] ALU_OP_MAX = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Codes above the highest defined op are rejected without using the ALU
    function automatic logic op_illegal(input logic [3:0] ctrl, input logic [3:0] op_max);
        return ctrl > op_max;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to
// the requester that was not granted last.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o,
    output logic       grant_idx_o
);

    // Pick the winner index, then expand to a one-hot grant (zero when idle)
    always_comb begin
        grant_idx_o = 1'b0;
        grant_o     = 2'b00;
        if (&valid_i) begin
            grant_idx_o = ~last_grant_i;
        end else begin
            grant_idx_o = valid_i[1];
        end
        if (|valid_i) begin
            grant_o = grant_idx_o ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters. One op in flight at a
// time: IDLE (grant/capture) -> EXEC (ALU driven) -> RESP (hold result).
// Illegal op codes skip EXEC and answer with rsp_err.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int                WIDTH  = ALU_WIDTH,
    parameter int                CTRL_W = ALU_CTRL_W,
    parameter logic [CTRL_W-1:0] OP_MAX = CTRL_W'(ALU_OP_MAX)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*WIDTH-1:0]    req_srca,
    input  logic [2*WIDTH-1:0]    req_srcb,
    input  logic [2*CTRL_W-1:0]   req_ctrl,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_zero,
    output logic                  rsp_err,
    output logic [WIDTH-1:0]      alu_srca,
    output logic [WIDTH-1:0]      alu_srcb,
    output logic [CTRL_W-1:0]     alu_ctrl,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  alu_zero
);

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic [WIDTH-1:0]    srca_q, srca_d, srcb_q, srcb_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [WIDTH-1:0]    res_q, res_d;
    logic                zero_q, zero_d, err_q, err_d;

    logic [1:0]          gnt;
    logic                gnt_idx;
    logic [WIDTH-1:0]    sel_a, sel_b;
    logic [CTRL_W-1:0]   sel_c;

    rr_arb2 u_arb (
        .valid_i      (req_valid),
        .last_grant_i (last_q),
        .grant_o      (gnt),
        .grant_idx_o  (gnt_idx)
    );

    assign sel_a = gnt_idx ? req_srca[2*WIDTH-1:WIDTH]   : req_srca[WIDTH-1:0];
    assign sel_b = gnt_idx ? req_srcb[2*WIDTH-1:WIDTH]   : req_srcb[WIDTH-1:0];
    assign sel_c = gnt_idx ? req_ctrl[2*CTRL_W-1:CTRL_W] : req_ctrl[CTRL_W-1:0];

    // ALU inputs come straight from the capture registers, so they stay put
    // between ops instead of following the request buses.
    assign alu_srca   = srca_q;
    assign alu_srcb   = srcb_q;
    assign alu_ctrl   = ctrl_q;
    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Capture, result and arbitration-history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= 1'b0;
            last_q  <= 1'b1;   // req 0 wins the first tie
            srca_q  <= '0;
            srcb_q  <= '0;
            ctrl_q  <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            srca_q  <= srca_d;
            srcb_q  <= srcb_d;
            ctrl_q  <= ctrl_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    // Next state, captures and handshake outputs
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        srca_d    = srca_q;
        srcb_d    = srcb_q;
        ctrl_d    = ctrl_q;
        res_d     = res_q;
        zero_d    = zero_q;
        err_d     = err_q;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        case (state_q)
            ST_IDLE: begin
                req_ready = gnt;
                if (|gnt) begin
                    owner_d = gnt_idx;
                    last_d  = gnt_idx;
                    srca_d  = sel_a;
                    srcb_d  = sel_b;
                    ctrl_d  = sel_c;
                    if (sel_c > OP_MAX) begin
                        res_d   = '0;
                        zero_d  = 1'b0;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                res_d   = alu_result;
                zero_d  = alu_zero;
                err_d   = 1'b0;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [63:0] req_srca, req_srcb;
    logic [7:0]  req_ctrl;
    logic [31:0] rsp_result, alu_srca, alu_srcb, alu_result;
    logic        rsp_zero, rsp_err, alu_zero;
    logic [3:0]  alu_ctrl;

    int checks = 0;
    int errors = 0;
    int model_last;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_srca(req_srca), .req_srcb(req_srcb), .req_ctrl(req_ctrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    // Behavioural ALU: also the reference for expected results
    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return b;
            4'd8:  return a + b;
            4'd9:  return b;
            4'd10: return a << b[4:0];
            4'd11: return $signed(a) >>> b[4:0];
            4'd12: return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_result = ref_alu(alu_ctrl, alu_srca, alu_srcb);
        alu_zero   = (alu_result == 32'd0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int w, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        req_srca[w*32 +: 32] = a;
        req_srcb[w*32 +: 32] = b;
        req_ctrl[w*4 +: 4]   = c;
        req_valid[w]         = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_last = 1;
    endtask

    // Requester w is expected to win now; follow its op through to the response
    // on a fixed schedule, holding the response dly extra cycles before taking it.
    task automatic serve(input int w, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                         input logic [31:0] er, input logic ez, input logic ee, input int dly);
        logic [1:0] own;
        own = (w == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        check("grant", req_ready, own);
        @(posedge clk); #1;
        req_valid[w] = 1'b0;
        model_last = w;
        if (!ee) begin
            @(negedge clk);
            check("exec_rsp_valid", rsp_valid, 2'b00);
            check("exec_ready", req_ready, 2'b00);
            check("exec_ctrl", alu_ctrl, c);
            check("exec_srca", alu_srca, a);
            check("exec_srcb", alu_srcb, b);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("rsp_valid", rsp_valid, own);
        check("rsp_result", rsp_result, er);
        check("rsp_zero", rsp_zero, ez);
        check("rsp_err", rsp_err, ee);
        check("resp_ready", req_ready, 2'b00);
        for (int i = 0; i < dly; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("hold_valid", rsp_valid, own);
            check("hold_result", rsp_result, er);
            check("hold_zero", rsp_zero, ez);
            check("hold_ready", req_ready, 2'b00);
        end
        rsp_ready[w] = 1'b1;
        #1 check("hs_ready", req_ready, 2'b00);
        @(posedge clk); #1;
        rsp_ready = 2'b00;
    endtask

    typedef struct {
        int          w;
        logic [31:0] a, b;
        logic [3:0]  c;
        logic [31:0] r;
        logic        z, e;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
        req_srca = '0; req_srcb = '0; req_ctrl = '0;
        model_last = 1;

        tbl[0] = '{0, 32'd5, 32'd7, 4'd0, 32'd12, 1'b0, 1'b0};
        tbl[1] = '{1, 32'd5, 32'd5, 4'd1, 32'd0, 1'b1, 1'b0};
        tbl[2] = '{0, 32'h0000F0F0, 32'h00000FF0, 4'd2, 32'h000000F0, 1'b0, 1'b0};
        tbl[3] = '{1, 32'hF0000000, 32'h1, 4'd3, 32'hF0000001, 1'b0, 1'b0};
        tbl[4] = '{0, 32'hFFFFFFFF, 32'h1, 4'd5, 32'h1, 1'b0, 1'b0};
        tbl[5] = '{1, 32'hFFFFFFFF, 32'h1, 4'd6, 32'h0, 1'b1, 1'b0};
        tbl[6] = '{0, 32'h80000000, 32'd4, 4'd11, 32'hF8000000, 1'b0, 1'b0};
        tbl[7] = '{1, 32'h80000000, 32'd4, 4'd12, 32'h08000000, 1'b0, 1'b0};
        tbl[8] = '{0, 32'd9, 32'd9, 4'd15, 32'h0, 1'b0, 1'b1};
        tbl[9] = '{1, 32'd1, 32'd2, 4'd13, 32'h0, 1'b0, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_result", rsp_result, 32'd0);
        check("rst_zero", rsp_zero, 1'b0);
        check("rst_err", rsp_err, 1'b0);
        check("rst_alu_a", alu_srca, 32'd0);
        check("rst_alu_b", alu_srcb, 32'd0);
        check("rst_alu_ctrl", alu_ctrl, 4'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Tie from reset: req0 first (held 5 cycles, req1's rsp_ready ignored), then req1, then req0 again
        set_req(0, 32'h000000F0, 32'h0000000F, 4'd4);
        set_req(1, 32'd1, 32'd4, 4'd10);
        rsp_ready = 2'b10;
        serve(0, 32'h000000F0, 32'h0000000F, 4'd4, 32'hFF, 1'b0, 1'b0, 5);
        serve(1, 32'd1, 32'd4, 4'd10, 32'd16, 1'b0, 1'b0, 0);
        set_req(0, 32'd3, 32'd2, 4'd1);
        set_req(1, 32'd6, 32'd6, 4'd4);
        serve(0, 32'd3, 32'd2, 4'd1, 32'd1, 1'b0, 1'b0, 0);
        serve(1, 32'd6, 32'd6, 4'd4, 32'd0, 1'b1, 1'b0, 1);

        // Directed vectors, one requester at a time
        for (int i = 0; i < 10; i++) begin
            set_req(tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].c);
            serve(tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].r, tbl[i].z, tbl[i].e, i % 3);
        end

        // Valid dropped before grant: nothing captured, no response
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) begin
            @(negedge clk);
            check("idle_rsp_valid", rsp_valid, 2'b00);
        end
        @(posedge clk); #1;

        // Reset during EXEC
        set_req(0, 32'd3, 32'd4, 4'd0);
        @(negedge clk);
        check("pre_rst_grant", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", rsp_valid, 2'b00);
        check("midrst_ready", req_ready, 2'b00);
        check("midrst_alu_a", alu_srca, 32'd0);
        check("midrst_alu_ctrl", alu_ctrl, 4'd0);
        check("midrst_result", rsp_result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_last = 1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_valid", rsp_valid, 2'b00);
        end
        @(posedge clk); #1;
        set_req(0, 32'd1, 32'd1, 4'd0);
        serve(0, 32'd1, 32'd1, 4'd0, 32'd2, 1'b0, 1'b0, 0);

        // Random traffic against the round-robin / ALU reference model
        for (int it = 0; it < 40; it++) begin
            logic [31:0] a[2], b[2];
            logic [3:0]  c[2];
            int          pend, win;
            logic        e;
            logic [31:0] r;
            pend = $urandom_range(1, 3);
            for (int k = 0; k < 2; k++) begin
                a[k] = $urandom;
                b[k] = ($urandom_range(0, 3) == 0) ? a[k] : $urandom;
                c[k] = 4'($urandom_range(0, 15));
                if (pend[k]) set_req(k, a[k], b[k], c[k]);
            end
            while (pend != 0) begin
                if (pend == 3) win = 1 - model_last;
                else           win = (pend == 1) ? 0 : 1;
                e = (c[win] > 4'd12);
                r = e ? 32'd0 : ref_alu(c[win], a[win], b[win]);
                serve(win, a[win], b[win], c[win], r, e ? 1'b0 : (r == 32'd0), e, $urandom_range(0, 3));
                pend = pend & ~(1 << win);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
